// File: rtl/symcounter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : symcounter_pkg
// Purpose  : Shared state encoding, defaults and LFSR step for symbol_stream.
// Revision : 1.0
// ============================================================================
package symcounter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int          c_symbol_w_default = 4;
    localparam int          c_count_w_default  = 8;
    localparam logic [15:0] c_seed_default     = 16'hACE1;

    // Right-shifting Fibonacci form: polynomial taps 16,14,13,11 land on bits 0,2,3,5.
    localparam logic [15:0] c_lfsr_taps        = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {^(v & c_lfsr_taps), v[15:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/symbol_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : symbol_lfsr
// Purpose  : 16-bit Fibonacci LFSR that steps only when advance is high.
// Revision : 1.0
// ============================================================================
module symbol_lfsr
    import symcounter_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] value_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= seed;
        end else if (advance) begin
            value_q <= lfsr_step(value_q);
        end
    end

    assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/symbol_stream.sv
`default_nettype none
// ============================================================================
// Module   : symbol_stream
// Purpose  : Timed rounds of LFSR symbols (show/gap) counting magic-symbol hits.
//            Macro SYMSTREAM_MAGIC_BIAS_EN substitutes the magic symbol when lfsr[7:6]==0.
// Revision : 1.0
// ============================================================================
module symbol_stream
    import symcounter_pkg::*;
#(
    parameter int          SYMBOL_W     = c_symbol_w_default,
    parameter int          COUNT_W      = c_count_w_default,
    parameter int          NUM_SYMBOLS  = 32,
    parameter int          DWELL_CYCLES = 100000000,
    parameter int          GAP_CYCLES   = 25000000,
    parameter logic [15:0] SEED         = c_seed_default
)(
    input  logic                Clk100M,
    input  logic                Reset,
    input  logic                start,
    input  logic                stop,
    input  logic [SYMBOL_W-1:0] magicSymbol,
    output logic [SYMBOL_W-1:0] symbol,
    output logic                symbolVisible,
    output logic                symbolValid,
    output logic [COUNT_W-1:0]  magicSymbolCount,
    output logic                busy,
    output logic                done
);

    localparam int c_cyc_max = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int c_cyc_w   = $clog2(c_cyc_max + 1);
    localparam int c_idx_w   = $clog2(NUM_SYMBOLS + 1);

    localparam logic [c_cyc_w-1:0] c_dwell_last = c_cyc_w'(DWELL_CYCLES - 1);
    localparam logic [c_cyc_w-1:0] c_gap_last   = c_cyc_w'(GAP_CYCLES - 1);
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(NUM_SYMBOLS - 1);
    localparam logic [COUNT_W-1:0] c_count_max  = '1;

    state_e               state_q,  state_d;
    logic [c_cyc_w-1:0]   cyc_q,    cyc_d;
    logic [c_idx_w-1:0]   idx_q,    idx_d;
    logic [SYMBOL_W-1:0]  magic_q,  magic_d;
    logic [COUNT_W-1:0]   count_q,  count_d;
    logic [SYMBOL_W-1:0]  symbol_q, symbol_d;
    logic                 valid_q,  valid_d;

    logic                 emit;
    logic [15:0]          lfsr_value;
    logic [SYMBOL_W-1:0]  emit_magic;
    logic [SYMBOL_W-1:0]  emit_sym;
    logic                 unused_lfsr_bits;

    symbol_lfsr u_lfsr (
        .clock   (Clk100M),
        .reset   (Reset),
        .advance (emit),
        .seed    (SEED),
        .value   (lfsr_value)
    );

    // A restart compares against the magic value being latched on this same edge.
    assign emit_magic = start ? magicSymbol : magic_q;

`ifdef SYMSTREAM_MAGIC_BIAS_EN
    assign emit_sym = (lfsr_value[7:6] == 2'b00) ? emit_magic : lfsr_value[SYMBOL_W-1:0];
`else
    assign emit_sym = lfsr_value[SYMBOL_W-1:0];
`endif

    assign unused_lfsr_bits = ^lfsr_value;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        idx_d    = idx_q;
        magic_d  = magic_q;
        count_d  = count_q;
        symbol_d = symbol_q;
        valid_d  = 1'b0;
        emit     = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_SHOW: begin
                if (stop) begin
                    state_d  = S_IDLE;
                    cyc_d    = '0;
                    symbol_d = '0;
                end else if (cyc_q == c_dwell_last) begin
                    state_d  = S_GAP;
                    cyc_d    = '0;
                    symbol_d = '0;
                end else begin
                    cyc_d = cyc_q + c_cyc_w'(1);
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                    cyc_d   = '0;
                end else if (cyc_q == c_gap_last) begin
                    cyc_d = '0;
                    if (idx_q == c_idx_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHOW;
                        idx_d   = idx_q + c_idx_w'(1);
                        emit    = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + c_cyc_w'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d = S_SHOW;
            cyc_d   = '0;
            idx_d   = '0;
            magic_d = magicSymbol;
            count_d = '0;
            emit    = 1'b1;
        end

        if (emit) begin
            symbol_d = emit_sym;
            valid_d  = 1'b1;
            if ((emit_sym == emit_magic) && (count_d != c_count_max)) begin
                count_d = count_d + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            idx_q    <= '0;
            magic_q  <= '0;
            count_q  <= '0;
            symbol_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            idx_q    <= idx_d;
            magic_q  <= magic_d;
            count_q  <= count_d;
            symbol_q <= symbol_d;
            valid_q  <= valid_d;
        end
    end

    assign symbol           = symbol_q;
    assign symbolVisible    = (state_q == S_SHOW);
    assign symbolValid      = valid_q;
    assign magicSymbolCount = count_q;
    assign busy             = (state_q == S_SHOW) || (state_q == S_GAP);
    assign done             = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_symbol_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_symbol_stream
// Purpose  : Self-checking bench for symbol_stream against a round-timeline model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_symbol_stream;

    localparam int          SW    = 4;
    localparam int          CW    = 8;
    localparam int          NS    = 8;
    localparam int          DW    = 4;
    localparam int          GW    = 2;
    localparam int          P     = DW + GW;
    localparam int          ROUND = NS * P;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst, start, stop;
    logic [SW-1:0] magic;
    logic [SW-1:0] symbol;
    logic          symbolVisible, symbolValid, busy, done;
    logic [CW-1:0] magicSymbolCount;

    logic          start2;
    logic [0:0]    magic2, sym2;
    logic          vis2, val2, busy2, done2;
    logic [1:0]    cnt2;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    symbol_stream #(
        .SYMBOL_W(SW), .COUNT_W(CW), .NUM_SYMBOLS(NS),
        .DWELL_CYCLES(DW), .GAP_CYCLES(GW), .SEED(SEED)
    ) dut (
        .Clk100M(clk), .Reset(rst), .start(start), .stop(stop),
        .magicSymbol(magic), .symbol(symbol), .symbolVisible(symbolVisible),
        .symbolValid(symbolValid), .magicSymbolCount(magicSymbolCount),
        .busy(busy), .done(done)
    );

    // Count width deliberately narrower than the round so saturation is reachable.
    symbol_stream #(
        .SYMBOL_W(1), .COUNT_W(2), .NUM_SYMBOLS(12),
        .DWELL_CYCLES(1), .GAP_CYCLES(1), .SEED(SEED)
    ) u_sat (
        .Clk100M(clk), .Reset(rst), .start(start2), .stop(1'b0),
        .magicSymbol(magic2), .symbol(sym2), .symbolVisible(vis2),
        .symbolValid(val2), .magicSymbolCount(cnt2),
        .busy(busy2), .done(done2)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic [3:0] pick(input logic [15:0] l, input logic [3:0] mg, input int w);
        logic [3:0] s;
        s = l[3:0];
`ifdef SYMSTREAM_MAGIC_BIAS_EN
        if (l[7:6] == 2'b00) s = mg;
`endif
        if (w == 1) s = {3'b000, s[0]};
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: position m_t within the round timeline (1 = first SHOW cycle).
    logic [15:0] m_lfsr;
    bit          m_act;
    int          m_t, m_cnt;
    logic [3:0]  m_sym, m_magic;

    always @(posedge clk or posedge rst) begin : model
        logic [15:0] l;
        int          t, c;
        bit          a;
        logic [3:0]  s, mg;
        if (rst) begin
            m_lfsr  <= SEED;
            m_act   <= 1'b0;
            m_t     <= 0;
            m_cnt   <= 0;
            m_sym   <= 4'h0;
            m_magic <= 4'h0;
        end else begin
            l = m_lfsr; t = m_t; c = m_cnt; a = m_act; s = m_sym; mg = m_magic;
            if (start) begin
                a = 1'b1; t = 1; mg = magic; c = 0;
            end else if (a && stop && t <= ROUND) begin
                a = 1'b0;
            end else if (a) begin
                t = t + 1;
                if (t > ROUND + 1) a = 1'b0;
            end
            if (a && t <= ROUND && ((t - 1) % P) == 0) begin
                s = pick(l, mg, SW);
                if (s == mg && c < 255) c = c + 1;
                l = lfsr_next(l);
            end
            m_lfsr <= l; m_t <= t; m_cnt <= c; m_act <= a; m_sym <= s; m_magic <= mg;
        end
    end

    int         e_off;
    logic       e_busy, e_vis, e_valid, e_done;
    logic [3:0] e_sym;
    logic [7:0] e_cnt;

    always_comb begin
        e_off   = (m_t > 0) ? (m_t - 1) % P : 0;
        e_busy  = m_act && (m_t <= ROUND);
        e_vis   = e_busy && (e_off < DW);
        e_valid = e_busy && (e_off == 0);
        e_sym   = e_vis ? m_sym : 4'h0;
        e_done  = m_act && (m_t == ROUND + 1);
        e_cnt   = m_cnt[7:0];
    end

    always @(negedge clk) begin
        if (checking)
            check("cycle{sym,vis,valid,cnt,busy,done}",
                  {16'h0, symbol, symbolVisible, symbolValid, magicSymbolCount, busy, done},
                  {16'h0, e_sym, e_vis, e_valid, e_cnt, e_busy, e_done});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0]  lit_syms [8] = '{4'h1, 4'h0, 4'h8, 4'hC, 4'hE, 4'h7, 4'h3, 4'h9};
    logic [15:0] l2, l;
    logic [3:0]  s2, mg, cand;
    int          exp2, nvalid, done_cyc, hits, cnt_before, n;
    bit          seen_done, found;

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; magic = '0; start2 = 1'b0; magic2 = '0;
        #2 rst = 1'b1;
        tick(); tick();
        checking = 1;
        check("reset_outputs", {symbol, symbolVisible, symbolValid, magicSymbolCount, busy, done}, 0);
        check("reset_sat_outputs", {sym2, vis2, val2, cnt2, busy2, done2}, 0);
        rst = 1'b0;
        tick();

        // Saturation on the narrow-count instance; first round pinned by hand (six 1-bits in twelve).
        l2 = SEED;
        for (int r = 0; r < 5; r++) begin
            magic2 = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            exp2 = 0;
            for (int k = 0; k < 12; k++) begin
                s2 = pick(l2, {3'b000, magic2}, 1);
                if (s2[0] == magic2[0] && exp2 < 3) exp2++;
                l2 = lfsr_next(l2);
            end
            start2 = 1'b1; tick(); start2 = 1'b0;
            for (n = 0; n < 60 && done2 !== 1'b1; n++) tick();
            check("sat_done_seen", done2, 1);
            check("sat_count", cnt2, exp2);
            if (r == 0) check("sat_count_literal", cnt2, 3);
            tick();
        end

        // First round after reset: timing and known symbol sequence.
        magic = 4'h8;
        start = 1'b1; tick(); start = 1'b0;
        check("valid_latency", symbolValid, 1);
        nvalid = 0; done_cyc = -1;
        for (int c = 1; c <= ROUND + 1; c++) begin
            if (symbolValid) begin
                check("valid_cycle", c, 1 + P * nvalid);
`ifndef SYMSTREAM_MAGIC_BIAS_EN
                if (nvalid < 8) check("symbol_literal", symbol, lit_syms[nvalid]);
`endif
                nvalid++;
            end
            if (done) done_cyc = c;
            if (c <= ROUND) tick();
        end
        check("done_cycle", done_cyc, 49);
        check("valid_pulses", nvalid, NS);
`ifndef SYMSTREAM_MAGIC_BIAS_EN
        check("magic_count_at_done", magicSymbolCount, 1);
`endif
        tick();
        check("busy_after_done", {busy, done}, 0);
        repeat (5) tick();
`ifndef SYMSTREAM_MAGIC_BIAS_EN
        check("count_held_idle", magicSymbolCount, 1);
`endif
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_in_idle", {busy, symbolValid}, 0);

        // Stop in the gap following symbol 5.
        magic = 4'($urandom);
        start = 1'b1; tick(); start = 1'b0;
        repeat (28) tick();
        check("in_gap_sym5", {busy, symbolVisible, symbol}, {1'b1, 1'b0, 4'h0});
        cnt_before = magicSymbolCount;
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_to_idle", {busy, symbolVisible, symbol}, 0);
        check("stop_count_kept", magicSymbolCount, cnt_before);
        seen_done = 0;
        repeat (30) begin tick(); if (done) seen_done = 1; end
        check("stop_no_done", seen_done, 0);

        // start and stop together mid-round: start wins.
        magic = 4'($urandom);
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        mg = pick(m_lfsr, 4'h0, SW) ^ 4'h1;
        magic = mg; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("restart_valid", {symbolValid, busy}, 2'b11);
`ifndef SYMSTREAM_MAGIC_BIAS_EN
        check("restart_count", magicSymbolCount, 0);
`endif
        repeat (60) tick();

        // Find a magic value hit three times in the next round, then reset mid-SHOW.
        found = 0; cand = 4'h0;
        for (int a = 0; a < 200 && !found; a++) begin
            for (int v = 0; v < 16 && !found; v++) begin
                l = m_lfsr; hits = 0;
                for (int k = 0; k < NS; k++) begin
                    if (pick(l, 4'(v), SW) == 4'(v)) hits++;
                    l = lfsr_next(l);
                end
                if (hits >= 3) begin found = 1; cand = 4'(v); end
            end
            if (!found) begin
                start = 1'b1; tick(); start = 1'b0;
                stop = 1'b1; tick(); stop = 1'b0;
            end
        end
        check("reset_setup_found", found, 1);
        magic = cand;
        start = 1'b1; tick(); start = 1'b0;
        for (n = 0; n < ROUND && m_cnt < 3; n++) tick();
        check("count_before_reset", {symbolVisible, magicSymbolCount}, {1'b1, 8'd3});
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {symbol, symbolVisible, symbolValid, magicSymbolCount, busy, done}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("idle_after_reset", {busy, done}, 0);
        magic = 4'h0;
        start = 1'b1; tick(); start = 1'b0;
        check("seed_symbol0", {symbolValid, symbol}, {1'b1, 4'h1});
        repeat (P) tick();
        check("seed_symbol1", {symbolValid, symbol}, {1'b1, 4'h0});
        stop = 1'b1; tick(); stop = 1'b0;

        // Randomised traffic: restarts, stops, magic changes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 79) == 0);
            stop  = ($urandom_range(0, 24) == 0);
            magic = 4'($urandom);
            rst   = ($urandom_range(0, 599) == 0);
            tick();
        end
        start = 1'b0; stop = 1'b0; rst = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
